// File: rtl/me_pkg.sv
// Shared ME datapath package: FSM state encoding, default pixel geometry,
// and width helpers common to the SAD row and the search-window controller.
package me_pkg;

    typedef logic [2:0] me_state_t;

    localparam me_state_t ST_IDLE  = 3'd0;
    localparam me_state_t ST_ACCUM = 3'd1;
    localparam me_state_t ST_DRAIN = 3'd2;
    localparam me_state_t ST_CMP   = 3'd3;
    localparam me_state_t ST_OUT   = 3'd4;

    localparam int ME_PIX_W   = 8;
    localparam int ME_PIX_CNT = 64;

    // Worst case block SAD is PIX_CNT*(2^PIX_W-1), which fits in ACC_W bits.
    function automatic int me_acc_w(input int pix_w, input int pix_cnt);
        return pix_w + $clog2(pix_cnt);
    endfunction

    function automatic int me_idx_w(input int ncand);
        return (ncand > 1) ? $clog2(ncand) : 1;
    endfunction

endpackage

// File: rtl/me_sad_pe.sv
// One SAD lane: subtract, abs and accumulate stages, advanced only by
// valid tokens; clr zeroes the accumulator at the start of a block.
module me_sad_pe #(
    parameter int PIX_W = 8,
    parameter int ACC_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic             clr,
    input  logic [PIX_W-1:0] cur_pix,
    input  logic [PIX_W-1:0] ref_pix,
    output logic [ACC_W-1:0] acc
);

    localparam int STAGES = 2;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;
    logic [PIX_W:0]  diff_q;
    logic [PIX_W-1:0] abs_n;
    logic [PIX_W-1:0] abs_q;

    assign vld_pipe = {vld_q, in_vld};

    // diff_q is a PIX_W+1 bit two's complement value; its magnitude fits PIX_W.
    assign abs_n = diff_q[PIX_W] ? PIX_W'(~diff_q + {{PIX_W{1'b0}}, 1'b1})
                                 : diff_q[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            diff_q <= '0;
            abs_q  <= '0;
            acc    <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0])
                diff_q <= {1'b0, cur_pix} - {1'b0, ref_pix};
            if (vld_pipe[1])
                abs_q <= abs_n;
            if (clr)
                acc <= '0;
            else if (vld_pipe[2])
                acc <= acc + ACC_W'(abs_q);
        end
    end

endmodule

// File: rtl/me_sad_row.sv
// Motion-estimation SAD row: NCAND lanes accumulate block SADs, then a serial
// min search emits (sad, idx, tag). Optional ME_THRESH_EN adds thresh/below_thresh.
module me_sad_row
    import me_pkg::*;
#(
    parameter int PIX_W   = ME_PIX_W,
    parameter int NCAND   = 8,
    parameter int PIX_CNT = ME_PIX_CNT,
    parameter int TAG_W   = 8,
    parameter int IDX_W   = me_idx_w(NCAND),
    parameter int ACC_W   = me_acc_w(PIX_W, PIX_CNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_W-1:0]       in_cur,
    input  logic [NCAND*PIX_W-1:0] in_ref,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef ME_THRESH_EN
    input  logic [ACC_W-1:0]       thresh,
    output logic                   below_thresh,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sad,
    output logic [IDX_W-1:0]       out_idx,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int CNT_W = $clog2(PIX_CNT + 1);
    localparam int CW    = $clog2(NCAND + 1);

    me_state_t                   state;
    logic [CNT_W-1:0]            cnt;
    logic                        drn;
    logic [CW-1:0]               cmp_cnt;
    logic [TAG_W-1:0]            tag_q;
    logic [NCAND-1:0][ACC_W-1:0] acc;
    logic [ACC_W-1:0]            sel_n;
    logic [ACC_W-1:0]            sel_sad;
    logic [IDX_W-1:0]            sel_idx;
    logic [ACC_W-1:0]            best_sad;
    logic [IDX_W-1:0]            best_idx;
    logic                        beat;
    logic                        blk_start;
    logic                        take;

    assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
    assign beat      = in_valid && in_ready;
    assign blk_start = beat && (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign out_sad   = best_sad;
    assign out_idx   = best_idx;
    assign out_tag   = tag_q;

    for (genvar k = 0; k < NCAND; k++) begin : g_pe
        me_sad_pe #(
            .PIX_W (PIX_W),
            .ACC_W (ACC_W)
        ) u_pe (
            .clk     (clk),
            .reset   (reset),
            .in_vld  (beat),
            .clr     (blk_start),
            .cur_pix (in_cur),
            .ref_pix (in_ref[k*PIX_W +: PIX_W]),
            .acc     (acc[k])
        );
    end

    // The lane mux is registered so the NCAND:1 select and the compare sit in
    // separate cycles; lane k is selected in CMP cycle k, compared in k+1.
    always_comb begin
        sel_n = '0;
        for (int k = 0; k < NCAND; k++)
            if (cmp_cnt == CW'(k))
                sel_n = acc[k];
    end

    // Lane 0 seeds the minimum; strict less-than keeps the lowest index on ties.
    assign take = (state == ST_CMP) && (cmp_cnt != '0) &&
                  ((sel_idx == '0) || (sel_sad < best_sad));

`ifdef ME_THRESH_EN
    logic [ACC_W-1:0] thr_q;
    logic             below_q;

    assign below_thresh = below_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q   <= '0;
            below_q <= 1'b0;
        end else begin
            if (blk_start)
                thr_q <= thresh;
            if (take)
                below_q <= (sel_sad <= thr_q);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            drn      <= 1'b0;
            cmp_cnt  <= '0;
            tag_q    <= '0;
            sel_sad  <= '0;
            sel_idx  <= '0;
            best_sad <= '0;
            best_idx <= '0;
        end else begin
            if (take) begin
                best_sad <= sel_sad;
                best_idx <= sel_idx;
            end
            case (state)
                ST_IDLE: begin
                    if (beat) begin
                        cnt   <= CNT_W'(1);
                        tag_q <= in_tag;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(PIX_CNT - 1)) begin
                            drn   <= 1'b0;
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    drn <= 1'b1;
                    if (drn) begin
                        cmp_cnt <= '0;
                        state   <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    cmp_cnt <= cmp_cnt + CW'(1);
                    sel_sad <= sel_n;
                    sel_idx <= IDX_W'(cmp_cnt);
                    if (cmp_cnt == CW'(NCAND))
                        state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_sad_row.sv
// Directed bench for me_sad_row (PIX_W=8, NCAND=4, PIX_CNT=4); expected values
// are hand-computed. Define ME_THRESH_EN to also cover the threshold flag.
module tb_me_sad_row;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_cur;
    logic [31:0] in_ref;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_sad;
    logic [1:0]  out_idx;
    logic [7:0]  out_tag;
`ifdef ME_THRESH_EN
    logic [9:0]  thresh;
    logic        below_thresh;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    me_sad_row #(
        .PIX_W   (8),
        .NCAND   (4),
        .PIX_CNT (4),
        .TAG_W   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cur       (in_cur),
        .in_ref       (in_ref),
        .in_tag       (in_tag),
`ifdef ME_THRESH_EN
        .thresh       (thresh),
        .below_thresh (below_thresh),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sad      (out_sad),
        .out_idx      (out_idx),
        .out_tag      (out_tag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One block of 4 beats; tag differs after the first beat to prove capture.
    task automatic send_blk(input logic [7:0] c, input logic [31:0] r,
                            input logic [7:0] t, input bit gap);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_cur   = c;
            in_ref   = r;
            in_tag   = (i == 0) ? t : ~t;
            @(negedge clk);
            in_valid = 1'b0;
            if (gap && i < 3)
                @(negedge clk);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        chk({tag, "_ov_hi"}, 32'(out_valid), 1);
        chk({tag, "_ir_lo"}, 32'(in_ready), 0);
        @(negedge clk);
        chk({tag, "_ov_lo"}, 32'(out_valid), 0);
        chk({tag, "_ir_hi"}, 32'(in_ready), 1);
    endtask

    initial begin
        int lat;
        int seen;
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_cur    = '0;
        in_ref    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef ME_THRESH_EN
        thresh    = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sad",   32'(out_sad),   0);
        chk("rst_out_idx",   32'(out_idx),   0);
        chk("rst_out_tag",   32'(out_tag),   0);
`ifdef ME_THRESH_EN
        chk("rst_below",     32'(below_thresh), 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Tie-break: lane SADs {0,8,12,0}, lowest index wins.
        send_blk(8'd10, {8'd10, 8'd7, 8'd12, 8'd10}, 8'hA5, 1'b0);
        wait_out(lat);
        chk("tie_lat", 32'(lat),     7);
        chk("tie_sad", 32'(out_sad), 0);
        chk("tie_idx", 32'(out_idx), 0);
        chk("tie_tag", 32'(out_tag), 32'hA5);
        handshake("tie");

        // Extremes: SADs {1020,1020,1020,1016}, no wrap in 10 bits.
        send_blk(8'd0, {8'd254, 8'd255, 8'd255, 8'd255}, 8'h3C, 1'b0);
        wait_out(lat);
        chk("ext_lat", 32'(lat),     7);
        chk("ext_sad", 32'(out_sad), 1016);
        chk("ext_idx", 32'(out_idx), 3);
        chk("ext_tag", 32'(out_tag), 32'h3C);
        handshake("ext");

        // Gaps between beats: same result, latency from last accepted beat.
        send_blk(8'd10, {8'd10, 8'd7, 8'd12, 8'd10}, 8'h5A, 1'b1);
        wait_out(lat);
        chk("gap_lat", 32'(lat),     7);
        chk("gap_sad", 32'(out_sad), 0);
        chk("gap_idx", 32'(out_idx), 0);
        chk("gap_tag", 32'(out_tag), 32'h5A);
        handshake("gap");

        // Backpressure: SADs {20,8,40,32}; held 5 cycles while junk beats are offered.
        out_ready = 1'b0;
`ifdef ME_THRESH_EN
        thresh = 10'd8;
`endif
        send_blk(8'd20, {8'd28, 8'd30, 8'd18, 8'd25}, 8'h77, 1'b0);
        wait_out(lat);
        chk("bp_lat", 32'(lat),     7);
        chk("bp_sad", 32'(out_sad), 8);
        chk("bp_idx", 32'(out_idx), 1);
`ifdef ME_THRESH_EN
        chk("thr8_below", 32'(below_thresh), 1);
`endif
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_cur   = 8'd0;
            in_ref   = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("bp_hold_ov",  32'(out_valid), 1);
            chk("bp_hold_sad", 32'(out_sad),   8);
            chk("bp_hold_ir",  32'(in_ready),  0);
        end
        chk("bp_hold_tag", 32'(out_tag), 32'h77);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ov", 32'(out_valid), 0);
        chk("bp_rel_ir", 32'(in_ready),  1);

`ifdef ME_THRESH_EN
        thresh = 10'd7;
        send_blk(8'd20, {8'd28, 8'd30, 8'd18, 8'd25}, 8'h78, 1'b0);
        wait_out(lat);
        chk("thr7_sad",   32'(out_sad), 8);
        chk("thr7_below", 32'(below_thresh), 0);
        @(negedge clk);
`endif

        // Reset mid-block: partial block discarded, next block starts clean.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_cur   = 8'd0;
            in_ref   = 32'hFFFF_FFFF;
            in_tag   = 8'h11;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid)
                seen++;
        end
        chk("rst_mid_ov", 32'(seen),     0);
        chk("rst_mid_ir", 32'(in_ready), 1);
        send_blk(8'd10, {8'd14, 8'd7, 8'd12, 8'd11}, 8'h99, 1'b0);
        wait_out(lat);
        chk("post_lat", 32'(lat),     7);
        chk("post_sad", 32'(out_sad), 4);
        chk("post_idx", 32'(out_idx), 0);
        chk("post_tag", 32'(out_tag), 32'h99);
        handshake("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
